mux_select_sequencer: RTL and testbench

- Upstream control stage for the 8:1 select-based multiplexer (`multiplexer`).
- Accepts an 8-bit word through a valid/ready handshake and holds it on `y`.
- Steps the select lines s2,s1,s0 through 0..7 so the multiplexer emits the word LSB-first on its `x` output, one bit per step.
- Signals each bit-stable interval and word completion to downstream logic.

---
 rtl/mux_select_sequencer_if.sv | 37 +++
 rtl/mux_select_sequencer.sv | 133 +++++++++++++
 tb/tb_mux_select_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mux_select_sequencer_if.sv
// Handshake and select bus between the upstream controller and mux_select_sequencer.
// SEQ_LOOPBACK_CHECK_EN adds the multiplexer loopback bit x and the chk_err flag.
interface mux_select_sequencer_if;
  logic       load;
  logic [7:0] din;
  logic       abort;
  logic       ready;
  logic       busy;
  logic [7:0] y;
  logic       s2;
  logic       s1;
  logic       s0;
  logic       bit_valid;
  logic       done;
`ifdef SEQ_LOOPBACK_CHECK_EN
  logic       x;
  logic       chk_err;

  modport master (
    output load, din, abort, x,
    input  ready, busy, y, s2, s1, s0, bit_valid, done, chk_err
  );
  modport slave (
    input  load, din, abort, x,
    output ready, busy, y, s2, s1, s0, bit_valid, done, chk_err
  );
`else
  modport master (
    output load, din, abort,
    input  ready, busy, y, s2, s1, s0, bit_valid, done
  );
  modport slave (
    input  load, din, abort,
    output ready, busy, y, s2, s1, s0, bit_valid, done
  );
`endif
endinterface

// File: rtl/mux_select_sequencer.sv
// Sequences select lines 0..7 of an 8:1 multiplexer so a held word leaves LSB-first.
// Optional SEQ_LOOPBACK_CHECK_EN captures the multiplexer output and flags mismatches.
module mux_select_sequencer #(
  parameter int STEP_DIV = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mux_select_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] DIV_LAST = 4'(STEP_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] y_q, y_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] div_q, div_d;
  logic       step_end_s;

  // Last cycle of a select hold interval: the multiplexer output is settled.
  assign step_end_s = (state_q == ST_RUN) && (div_q == DIV_LAST);

  // Next-state logic; abort outranks normal stepping.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    div_d   = div_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          y_d     = bus.din;
          sel_d   = 3'd0;
          div_d   = 4'd0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          sel_d   = 3'd0;
          div_d   = 4'd0;
        end else if (step_end_s) begin
          div_d = 4'd0;
          if (sel_q == 3'd7) begin
            state_d = ST_DONE;
            sel_d   = 3'd0;
          end else begin
            sel_d = sel_q + 3'd1;
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 3'd0;
        div_d   = 4'd0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= 8'h00;
      sel_q   <= 3'd0;
      div_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      div_q   <= div_d;
    end
  end

  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.y         = y_q;
  assign bus.s2        = sel_q[2];
  assign bus.s1        = sel_q[1];
  assign bus.s0        = sel_q[0];
  assign bus.bit_valid = step_end_s;
  assign bus.done      = (state_q == ST_DONE);

`ifdef SEQ_LOOPBACK_CHECK_EN
  logic [7:0] rx_q, rx_d;
  logic       chk_err_q, chk_err_d;

  // Capture x per settled bit; bit 7 lands on the same edge that enters DONE, so compare rx_d.
  always_comb begin
    rx_d      = rx_q;
    chk_err_d = chk_err_q;
    if (step_end_s) begin
      rx_d[sel_q] = bus.x;
    end else begin
      rx_d = rx_q;
    end
    if ((state_q == ST_IDLE) && bus.load) begin
      chk_err_d = 1'b0;
    end else if (step_end_s && !bus.abort && (sel_q == 3'd7)) begin
      chk_err_d = (rx_d != y_q);
    end else begin
      chk_err_d = chk_err_q;
    end
  end

  // Loopback capture and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q      <= 8'h00;
      chk_err_q <= 1'b0;
    end else begin
      rx_q      <= rx_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign bus.chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench: cycle table on a STEP_DIV=1 instance, hand sequences on STEP_DIV=3.
module tb_mux_select_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  mux_select_sequencer_if bus1 ();
  mux_select_sequencer_if bus3 ();

  mux_select_sequencer #(.STEP_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux_select_sequencer #(.STEP_DIV(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Multiplexer models driven by the sequencer outputs
  logic [2:0] sel1_s, sel3_s;
  logic       mux1_s, mux3_s;
  logic       inject = 1'b0;
  assign sel1_s = {bus1.s2, bus1.s1, bus1.s0};
  assign sel3_s = {bus3.s2, bus3.s1, bus3.s0};
  assign mux1_s = bus1.y[sel1_s];
  assign mux3_s = bus3.y[sel3_s];
`ifdef SEQ_LOOPBACK_CHECK_EN
  assign bus1.x = mux1_s ^ (inject && (sel1_s == 3'd3));
  assign bus3.x = mux3_s;
`endif

  typedef struct {
    logic       rst;
    logic       load;
    logic       abort;
    logic [7:0] din;
    logic       e_ready;
    logic       e_busy;
    logic [7:0] e_y;
    logic [2:0] e_sel;
    logic       e_bv;
    logic       e_done;
    logic       e_x;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic r, logic ld, logic ab, logic [7:0] d,
                              logic rdy, logic bsy, logic [7:0] yy,
                              logic [2:0] sl, logic bv, logic dn, logic xx);
    vec_t v;
    v.rst = r; v.load = ld; v.abort = ab; v.din = d;
    v.e_ready = rdy; v.e_busy = bsy; v.e_y = yy; v.e_sel = sl;
    v.e_bv = bv; v.e_done = dn; v.e_x = xx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  initial begin
    bus1.load = 1'b0; bus1.abort = 1'b0; bus1.din = 8'h00;
    bus3.load = 1'b0; bus3.abort = 1'b0; bus3.din = 8'h00;

    //              rst ld ab din    rdy bsy y      sel  bv dn x
    vecs[0]  = mk(1'b1,1'b1,1'b0,8'hFF, 1'b1,1'b0,8'h00,3'd0,1'b0,1'b0,1'b0);
    vecs[1]  = mk(1'b1,1'b1,1'b0,8'hFF, 1'b1,1'b0,8'h00,3'd0,1'b0,1'b0,1'b0);
    vecs[2]  = mk(1'b0,1'b1,1'b0,8'hAA, 1'b0,1'b1,8'hAA,3'd0,1'b1,1'b0,1'b0);
    vecs[3]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'hAA,3'd1,1'b1,1'b0,1'b1);
    vecs[4]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'hAA,3'd2,1'b1,1'b0,1'b0);
    vecs[5]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'hAA,3'd3,1'b1,1'b0,1'b1);
    vecs[6]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'hAA,3'd4,1'b1,1'b0,1'b0);
    vecs[7]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'hAA,3'd5,1'b1,1'b0,1'b1);
    vecs[8]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'hAA,3'd6,1'b1,1'b0,1'b0);
    vecs[9]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'hAA,3'd7,1'b1,1'b0,1'b1);
    vecs[10] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'hAA,3'd0,1'b0,1'b1,1'b0);
    vecs[11] = mk(1'b0,1'b1,1'b1,8'h33, 1'b1,1'b0,8'hAA,3'd0,1'b0,1'b0,1'b0);
    vecs[12] = mk(1'b0,1'b1,1'b1,8'h3C, 1'b0,1'b1,8'h3C,3'd0,1'b1,1'b0,1'b0);
    vecs[13] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h3C,3'd1,1'b1,1'b0,1'b0);
    vecs[14] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h3C,3'd2,1'b1,1'b0,1'b1);
    vecs[15] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h3C,3'd3,1'b1,1'b0,1'b1);
    vecs[16] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h3C,3'd4,1'b1,1'b0,1'b1);
    vecs[17] = mk(1'b0,1'b0,1'b1,8'h00, 1'b1,1'b0,8'h3C,3'd0,1'b0,1'b0,1'b0);
    vecs[18] = mk(1'b0,1'b1,1'b0,8'h0F, 1'b0,1'b1,8'h0F,3'd0,1'b1,1'b0,1'b1);
    vecs[19] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h0F,3'd1,1'b1,1'b0,1'b1);
    vecs[20] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h0F,3'd2,1'b1,1'b0,1'b1);
    vecs[21] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h0F,3'd3,1'b1,1'b0,1'b1);
    vecs[22] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h0F,3'd4,1'b1,1'b0,1'b0);
    vecs[23] = mk(1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,8'h0F,3'd5,1'b1,1'b0,1'b0);
    vecs[24] = mk(1'b1,1'b1,1'b0,8'h00, 1'b1,1'b0,8'h00,3'd0,1'b0,1'b0,1'b0);
    vecs[25] = mk(1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,8'h00,3'd0,1'b0,1'b0,1'b0);

    // Each row: drive inputs, take one edge, check the post-edge outputs.
    for (int i = 0; i < 26; i++) begin
      rst = vecs[i].rst; bus1.load = vecs[i].load;
      bus1.abort = vecs[i].abort; bus1.din = vecs[i].din;
      @(posedge clk); #1;
      chk($sformatf("v%0d ready", i), 32'(bus1.ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d busy", i), 32'(bus1.busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d y", i), 32'(bus1.y), 32'(vecs[i].e_y));
      chk($sformatf("v%0d sel", i), 32'(sel1_s), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d bit_valid", i), 32'(bus1.bit_valid), 32'(vecs[i].e_bv));
      chk($sformatf("v%0d done", i), 32'(bus1.done), 32'(vecs[i].e_done));
      if (vecs[i].e_bv) chk($sformatf("v%0d mux_x", i), 32'(mux1_s), 32'(vecs[i].e_x));
    end
    bus1.load = 1'b0; bus1.abort = 1'b0;

    // STEP_DIV=3: 5A held 3 cycles per bit, FF offered throughout RUN and DONE.
    bus3.din = 8'h5A; bus3.load = 1'b1;
    @(posedge clk); #1;
    bus3.din = 8'hFF;
    for (int n = 1; n <= 26; n++) begin
      if (n == 26) bus3.load = 1'b0;
      if (n <= 24) begin
        chk($sformatf("d3 c%0d sel", n), 32'(sel3_s), 32'((n - 1) / 3));
        chk($sformatf("d3 c%0d bv", n), 32'(bus3.bit_valid), 32'(((n - 1) % 3) == 2));
        chk($sformatf("d3 c%0d busy", n), 32'(bus3.busy), 32'd1);
      end else begin
        chk($sformatf("d3 c%0d sel", n), 32'(sel3_s), 32'd0);
        chk($sformatf("d3 c%0d bv", n), 32'(bus3.bit_valid), 32'd0);
      end
      chk($sformatf("d3 c%0d done", n), 32'(bus3.done), 32'(n == 25));
      chk($sformatf("d3 c%0d ready", n), 32'(bus3.ready), 32'(n == 26));
      chk($sformatf("d3 c%0d y", n), 32'(bus3.y), 32'h5A);
      @(posedge clk); #1;
    end
    chk("d3 idle after", 32'(bus3.ready), 32'd1);
    chk("d3 y kept", 32'(bus3.y), 32'h5A);

`ifdef SEQ_LOOPBACK_CHECK_EN
    // Clean loopback of C3, then a corrupted bit 3, then clear on the next load.
    for (int pass = 0; pass < 2; pass++) begin
      inject = (pass == 1);
      bus1.din = 8'hC3; bus1.load = 1'b1;
      @(posedge clk); #1;
      bus1.load = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
      end
      chk($sformatf("lb%0d done", pass), 32'(bus1.done), 32'd1);
      chk($sformatf("lb%0d chk_err", pass), 32'(bus1.chk_err), 32'(pass == 1));
      @(posedge clk); #1;
      chk($sformatf("lb%0d chk_err hold", pass), 32'(bus1.chk_err), 32'(pass == 1));
    end
    inject = 1'b0;
    bus1.din = 8'h01; bus1.load = 1'b1;
    @(posedge clk); #1;
    bus1.load = 1'b0;
    chk("lb chk_err cleared", 32'(bus1.chk_err), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
